motor_bridge_ctrl: RTL and testbench
====================================

Name: motor_bridge_ctrl

Overview:
- Downstream of the PWM generator. Consumes its fixed-duty PWM lines (pwm_250/220/150/0) plus per-wheel speed/direction commands.
- Drives the four H-bridge inputs (L298N-style IN1..IN4) for the left and right motors.
- Provides coast dead time on direction reversal and a command watchdog that stops the car if commands stop arriving.

Parameters:
- DEAD_CYCLES, 50000, clk cycles of forced coast on a direction reversal (1 ms at 50 MHz); must be ≥1.
- WDOG_CYCLES, 25000000, clk cycles without an accepted command before both motors are forced to stop; 0 disables the watchdog.

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  synchronous active-low reset
- pwm_250  in  1  PWM line, highest duty
- pwm_220  in  1  PWM line, middle duty
- pwm_150  in  1  PWM line, lowest duty
- pwm_0  in  1  constant-low PWM line
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  block can accept a command
- cmd_left_speed  in  2  00 stop, 01→150, 10→220, 11→250
- cmd_left_dir  in  1  1 forward, 0 reverse
- cmd_right_speed  in  2  as left
- cmd_right_dir  in  1  as left
- in1, in2  out  1 each  left bridge (forward: in1=pwm, in2=0)
- in3, in4  out  1 each  right bridge (forward: in3=pwm, in4=0)
- wdog_expired  out  1  sticky watchdog-stop flag

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - in1..in4=0, wdog_expired=0, cmd_ready=1.
  - Both channels go to IDLE; stored speed is cleared to 00 and stored dir to 1.
  - Watchdog counter is cleared.
  - A reset taken during DEAD abandons the pending command.
- Accept: a command is accepted when cmd_valid && cmd_ready at a clk edge. cmd_ready = neither channel is in DEAD.
- Per-channel FSM, identical for left and right:
  - IDLE: both bridge outputs 0 (coast).
  - DRIVE: the selected pwm line is routed to the dir-selected bridge input; the other input is 0.
  - DEAD: both outputs 0; the down-counter is loaded with DEAD_CYCLES-1.
- Transitions on accept, per channel:
  - new speed 00 → IDLE.
  - From IDLE with speed ≠00 → DRIVE with the new dir/speed. No dead time is applied from IDLE.
  - From DRIVE with the same dir → stay in DRIVE and update speed next cycle.
  - From DRIVE with a different dir and speed ≠00 → DEAD. The new speed/dir is latched as pending.
- DEAD exit: when the counter reaches 0 → DRIVE with the pending speed/dir. DEAD therefore lasts exactly DEAD_CYCLES cycles with outputs 0.
- Output timing:
  - Outputs are registered: in* at cycle n+1 reflects state and pwm_* sampled at cycle n.
  - Command-to-output latency is 2 clk: the state updates at the accept edge, the outputs on the next edge.
  - No glitch path exists from the pwm inputs to the outputs.
- Shoot-through guard: the pair (in1,in2) is never 1,1, and neither is (in3,in4), under any input sequence. Verification asserts this.
- Watchdog counter:
  - Reloads to 0 on every accept; otherwise increments and saturates.
  - When the count reaches WDOG_CYCLES-1 (and WDOG_CYCLES≠0): both channels → IDLE, any DEAD/pending is discarded, and wdog_expired←1.
  - wdog_expired stays 1 until the next accepted command clears it, on the same edge as the accept.
- Simultaneous events:
  - An accept on the expiry cycle wins: the command is applied, the counter reloads, and wdog_expired is not set.
  - If only one channel reverses, the other channel's command is applied immediately. cmd_ready stays low until the DEAD channel finishes.
- Width: the counters are sized with $clog2 of their parameter (+1). The watchdog counter never wraps.

Decomposition:
- Package motor_pkg:
  - speed encoding constants SPD_STOP/150/220/250.
  - DIR_FWD/DIR_REV.
  - channel state enum {IDLE, DRIVE, DEAD}.
- Sub-module motor_channel_fsm, instantiated twice:
  - handles the state, the dead counter, pending speed/dir, the pwm mux and the registered bridge pair.
  - inputs: accept, speed, dir, force_stop, pwm bus.
  - outputs: a_out, b_out, in_dead.
- Top level: the watchdog, cmd_ready, and wdog_expired.

Test Plan (DEAD_CYCLES=4, WDOG_CYCLES=20):
- Reset, then accept L=11 fwd, R=01 fwd → 2 cycles later in1 tracks pwm_250, in3 tracks pwm_150, in2=in4=0, cmd_ready=1.
- While L is in DRIVE fwd, accept L=10 rev → in1=in2=0 for exactly 4 cycles and cmd_ready=0 meanwhile; then in2 tracks pwm_220, in1=0.
- Issue no commands for 20 cycles after an accept → all in*=0, wdog_expired=1. The next accept (R=11 rev) clears the flag, and in4 tracks pwm_250.
- Watchdog expiry and an accept on the same edge → the command is applied and wdog_expired stays 0.
- rst_n=0 asserted for 1 cycle in the middle of a DEAD → the pending command is discarded, all outputs stay 0 afterwards, cmd_ready=1.
- Random commands and pwm inputs for 10k cycles → assertion never fires for in1&in2 or in3&in4. Every DEAD interval has outputs 0 for exactly 4 cycles.

Source files
------------

// File: rtl/motor_pkg.sv
// motor_pkg
// Shared definitions for the motor bridge controller:
//   - 2-bit speed command encoding (stop / 150 / 220 / 250 duty lines)
//   - direction encoding (1 = forward, 0 = reverse)
//   - per-channel state enum
//   - packed bundle of the incoming PWM lines, plus the speed-to-line selector
package motor_pkg;

  localparam logic [1:0] SPD_STOP = 2'b00;
  localparam logic [1:0] SPD_150  = 2'b01;
  localparam logic [1:0] SPD_220  = 2'b10;
  localparam logic [1:0] SPD_250  = 2'b11;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DEAD  = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic p250;
    logic p220;
    logic p150;
    logic p0;
  } pwm_bus_t;

  // Picks the PWM line that corresponds to a stored speed code.
  function automatic logic pwm_select(input logic [1:0] speed, input pwm_bus_t bus);
    logic sel;
    case (speed)
      SPD_150: sel = bus.p150;
      SPD_220: sel = bus.p220;
      SPD_250: sel = bus.p250;
      default: sel = bus.p0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/motor_channel_fsm.sv
// motor_channel_fsm
// One motor channel: IDLE / DRIVE / DEAD state, dead-time down-counter,
// pending speed/dir held across a reversal, PWM routing and the registered
// bridge input pair.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   accept        a command is being taken this edge
//   speed, dir    command fields for this channel
//   force_stop    watchdog expiry: drop to IDLE and discard any pending command
//   pwm_bus       the four incoming PWM lines
//   a_out, b_out  registered bridge inputs (a carries PWM forward, b reverse)
//   in_dead       channel is in its coast dead time
module motor_channel_fsm
  import motor_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept,
  input  logic [1:0] speed,
  input  logic       dir,
  input  logic       force_stop,
  input  pwm_bus_t   pwm_bus,
  output logic       a_out,
  output logic       b_out,
  output logic       in_dead
);

  localparam int unsigned DCW = $clog2(DEAD_CYCLES) + 1;
  localparam logic [DCW-1:0] DEAD_LOAD = DCW'(DEAD_CYCLES - 1);

  ch_state_e      state_q, state_d;
  logic [DCW-1:0] dead_cnt_q, dead_cnt_d;
  logic [1:0]     spd_q, spd_d;
  logic           dir_q, dir_d;
  logic [1:0]     pend_spd_q, pend_spd_d;
  logic           pend_dir_q, pend_dir_d;
  logic           a_q, a_d;
  logic           b_q, b_d;
  logic           pwm_sel;

  // Next-state logic. Watchdog stop outranks everything; a reversal from
  // DRIVE parks the new command in the pending registers until the dead
  // counter runs out, everything else takes effect immediately.
  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    spd_d      = spd_q;
    dir_d      = dir_q;
    pend_spd_d = pend_spd_q;
    pend_dir_d = pend_dir_q;
    if (force_stop) begin
      state_d    = IDLE;
      dead_cnt_d = '0;
      pend_spd_d = SPD_STOP;
      pend_dir_d = DIR_FWD;
    end else if (accept) begin
      if (speed == SPD_STOP) begin
        state_d = IDLE;
        spd_d   = SPD_STOP;
        dir_d   = dir;
      end else if (state_q == DRIVE && dir != dir_q) begin
        state_d    = DEAD;
        dead_cnt_d = DEAD_LOAD;
        pend_spd_d = speed;
        pend_dir_d = dir;
      end else begin
        state_d = DRIVE;
        spd_d   = speed;
        dir_d   = dir;
      end
    end else if (state_q == DEAD) begin
      if (dead_cnt_q == '0) begin
        state_d = DRIVE;
        spd_d   = pend_spd_q;
        dir_d   = pend_dir_q;
      end else begin
        dead_cnt_d = dead_cnt_q - DCW'(1);
      end
    end
  end

  // Bridge pair. Only one of a/b can ever be selected because they decode
  // opposite values of the same dir bit, so shoot-through is structurally
  // impossible. Both are registered so PWM edges never reach the pins
  // through combinational logic.
  always_comb begin
    pwm_sel = pwm_select(spd_q, pwm_bus);
    a_d     = (state_q == DRIVE) && (dir_q == DIR_FWD) && pwm_sel;
    b_d     = (state_q == DRIVE) && (dir_q == DIR_REV) && pwm_sel;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dead_cnt_q <= '0;
      spd_q      <= SPD_STOP;
      dir_q      <= DIR_FWD;
      pend_spd_q <= SPD_STOP;
      pend_dir_q <= DIR_FWD;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
      spd_q      <= spd_d;
      dir_q      <= dir_d;
      pend_spd_q <= pend_spd_d;
      pend_dir_q <= pend_dir_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign in_dead = (state_q == DEAD);

endmodule

// File: rtl/motor_bridge_ctrl.sv
// motor_bridge_ctrl
// Drives the four H-bridge inputs for the left (in1/in2) and right (in3/in4)
// motors from per-wheel speed/dir commands and the fixed-duty PWM lines.
// Adds coast dead time on reversal and a command watchdog.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   pwm_250/220/150/0                incoming PWM lines
//   cmd_valid / cmd_ready            command handshake
//   cmd_left_speed/dir, cmd_right_*  command fields
//   in1..in4                         registered bridge inputs
//   wdog_expired                     sticky watchdog-stop flag
module motor_bridge_ctrl
  import motor_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 50000,
  parameter int unsigned WDOG_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_250,
  input  logic       pwm_220,
  input  logic       pwm_150,
  input  logic       pwm_0,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_left_speed,
  input  logic       cmd_left_dir,
  input  logic [1:0] cmd_right_speed,
  input  logic       cmd_right_dir,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic       wdog_expired
);

  localparam int unsigned WCW = $clog2(WDOG_CYCLES) + 1;
  localparam bit WDOG_EN = (WDOG_CYCLES != 0);
  localparam logic [WCW-1:0] WDOG_LAST = WCW'(WDOG_EN ? WDOG_CYCLES - 1 : 0);

  pwm_bus_t       pwm_bus;
  logic           accept;
  logic           expire;
  logic           left_dead, right_dead;
  logic [WCW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic           wdog_expired_q, wdog_expired_d;

  assign pwm_bus   = {pwm_250, pwm_220, pwm_150, pwm_0};
  assign cmd_ready = !(left_dead || right_dead);
  assign accept    = cmd_valid && cmd_ready;
  // An accept on the expiry edge wins, so expiry is suppressed then.
  assign expire    = WDOG_EN && !accept && (wdog_cnt_q == WDOG_LAST);

  // Watchdog: cleared on accept, otherwise counts up and parks at the
  // expiry value so it can never wrap back into the quiet range.
  always_comb begin
    wdog_cnt_d     = wdog_cnt_q;
    wdog_expired_d = wdog_expired_q;
    if (accept) begin
      wdog_cnt_d     = '0;
      wdog_expired_d = 1'b0;
    end else begin
      if (WDOG_EN && wdog_cnt_q != WDOG_LAST) begin
        wdog_cnt_d = wdog_cnt_q + WCW'(1);
      end
      if (expire) begin
        wdog_expired_d = 1'b1;
      end
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt_q     <= '0;
      wdog_expired_q <= 1'b0;
    end else begin
      wdog_cnt_q     <= wdog_cnt_d;
      wdog_expired_q <= wdog_expired_d;
    end
  end

  assign wdog_expired = wdog_expired_q;

  motor_channel_fsm #(.DEAD_CYCLES(DEAD_CYCLES)) u_left (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (accept),
    .speed      (cmd_left_speed),
    .dir        (cmd_left_dir),
    .force_stop (expire),
    .pwm_bus    (pwm_bus),
    .a_out      (in1),
    .b_out      (in2),
    .in_dead    (left_dead)
  );

  motor_channel_fsm #(.DEAD_CYCLES(DEAD_CYCLES)) u_right (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (accept),
    .speed      (cmd_right_speed),
    .dir        (cmd_right_dir),
    .force_stop (expire),
    .pwm_bus    (pwm_bus),
    .a_out      (in3),
    .b_out      (in4),
    .in_dead    (right_dead)
  );

endmodule

// File: tb/tb_motor_bridge_ctrl.sv
// tb_motor_bridge_ctrl
// Directed and randomised stimulus for motor_bridge_ctrl with DEAD_CYCLES=4
// and WDOG_CYCLES=20. A behavioural model of each wheel and the watchdog
// predicts the outputs every cycle; directed steps also pin literal values.
module tb_motor_bridge_ctrl;

  localparam int DEAD = 4;
  localparam int WDOG = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_250 = 1'b0;
  logic       pwm_220 = 1'b0;
  logic       pwm_150 = 1'b0;
  logic       pwm_0 = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_left_speed = 2'b00;
  logic       cmd_left_dir = 1'b1;
  logic [1:0] cmd_right_speed = 2'b00;
  logic       cmd_right_dir = 1'b1;
  logic       cmd_ready;
  logic       in1, in2, in3, in4;
  logic       wdog_expired;

  int pass_count = 0;
  int check_count = 0;

  // Model state: per wheel the applied speed (0 = coasting) and direction,
  // the remaining coast cycles of a reversal and the command waiting behind
  // it; plus the number of edges since the last accepted command.
  int         m_spd [2];
  bit         m_dir [2];
  int         m_dead_left [2];
  int         m_pend_spd [2];
  bit         m_pend_dir [2];
  int         m_silent;
  bit         model_valid = 1'b0;
  logic [3:0] exp_in = 4'b0000;
  logic       exp_ready = 1'b1;
  logic       exp_expired = 1'b0;
  int         cmd_spd [2];
  bit         cmd_dir [2];
  bit         accepted;
  logic       p;

  logic [7:0] rev_exp [6];

  always #5 clk = ~clk;

  motor_bridge_ctrl #(.DEAD_CYCLES(DEAD), .WDOG_CYCLES(WDOG)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pwm_250         (pwm_250),
    .pwm_220         (pwm_220),
    .pwm_150         (pwm_150),
    .pwm_0           (pwm_0),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_left_speed  (cmd_left_speed),
    .cmd_left_dir    (cmd_left_dir),
    .cmd_right_speed (cmd_right_speed),
    .cmd_right_dir   (cmd_right_dir),
    .in1             (in1),
    .in2             (in2),
    .in3             (in3),
    .in4             (in4),
    .wdog_expired    (wdog_expired)
  );

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
  endtask

  // {2'b00, in1, in2, in3, in4, cmd_ready, wdog_expired}
  function automatic logic [7:0] dut_vec();
    return {2'b00, in1, in2, in3, in4, cmd_ready, wdog_expired};
  endfunction

  function automatic logic pwm_for(input int spd);
    case (spd)
      0:       return pwm_0;
      1:       return pwm_150;
      2:       return pwm_220;
      default: return pwm_250;
    endcase
  endfunction

  // Drive one command for exactly one clock edge.
  task automatic applyStimulus(input logic [1:0] ls, input logic ld, input logic [1:0] rs, input logic rd);
    @(negedge clk);
    cmd_valid       = 1'b1;
    cmd_left_speed  = ls;
    cmd_left_dir    = ld;
    cmd_right_speed = rs;
    cmd_right_dir   = rd;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model, advanced on each rising edge from the inputs held
  // stable since the previous falling edge. Outputs for the coming cycle
  // come from the pre-edge wheel state; ready/expired from the post-edge one.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_spd[c] = 0; m_dir[c] = 1'b1; m_dead_left[c] = 0;
        m_pend_spd[c] = 0; m_pend_dir[c] = 1'b1;
      end
      m_silent    = 0;
      exp_in      = 4'b0000;
      exp_ready   = 1'b1;
      exp_expired = 1'b0;
      model_valid = 1'b1;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (m_dead_left[c] == 0 && m_spd[c] != 0) begin
          p = pwm_for(m_spd[c]);
          exp_in[3 - 2*c] = m_dir[c] & p;
          exp_in[2 - 2*c] = ~m_dir[c] & p;
        end else begin
          exp_in[3 - 2*c] = 1'b0;
          exp_in[2 - 2*c] = 1'b0;
        end
      end
      cmd_spd[0] = int'(cmd_left_speed);  cmd_dir[0] = cmd_left_dir;
      cmd_spd[1] = int'(cmd_right_speed); cmd_dir[1] = cmd_right_dir;
      accepted = cmd_valid && m_dead_left[0] == 0 && m_dead_left[1] == 0;
      if (accepted) begin
        m_silent    = 0;
        exp_expired = 1'b0;
        for (int c = 0; c < 2; c++) begin
          if (cmd_spd[c] == 0) begin
            m_spd[c] = 0; m_dir[c] = cmd_dir[c];
          end else if (m_spd[c] != 0 && cmd_dir[c] != m_dir[c]) begin
            m_dead_left[c] = DEAD;
            m_pend_spd[c]  = cmd_spd[c];
            m_pend_dir[c]  = cmd_dir[c];
          end else begin
            m_spd[c] = cmd_spd[c]; m_dir[c] = cmd_dir[c];
          end
        end
      end else begin
        for (int c = 0; c < 2; c++) begin
          if (m_dead_left[c] > 0) begin
            m_dead_left[c]--;
            if (m_dead_left[c] == 0) begin
              m_spd[c] = m_pend_spd[c]; m_dir[c] = m_pend_dir[c];
            end
          end
        end
        if (m_silent < WDOG) m_silent++;
        if (WDOG != 0 && m_silent >= WDOG) begin
          for (int c = 0; c < 2; c++) begin
            m_spd[c] = 0; m_dead_left[c] = 0;
          end
          exp_expired = 1'b1;
        end
      end
      exp_ready = (m_dead_left[0] == 0 && m_dead_left[1] == 0);
    end
  end

  // Every falling edge once reset has been seen: full output vector against
  // the model, and neither bridge pair may ever be driven high on both legs.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model_outputs", dut_vec(), {2'b00, exp_in, exp_ready, exp_expired});
      checkOutput("shoot_through", {6'b000000, in1 & in2, in3 & in4}, 8'h00);
    end
  end

  // Safety net so the run always terminates.
  initial begin
    #5000000;
    $display("[TB] FAIL timeout: simulation did not reach its end, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence followed by randomised traffic.
  initial begin
    rev_exp[0] = 8'b00_1010_00;
    rev_exp[1] = 8'b00_0010_00;
    rev_exp[2] = 8'b00_0010_00;
    rev_exp[3] = 8'b00_0010_00;
    rev_exp[4] = 8'b00_0010_10;
    rev_exp[5] = 8'b00_0110_10;

    pwm_250 = 1'b1; pwm_220 = 1'b1; pwm_150 = 1'b1; pwm_0 = 1'b0;
    rst_n = 1'b0;
    idleCycles(2);
    checkOutput("reset_state", dut_vec(), 8'b00_0000_10);
    rst_n = 1'b1;

    // L=250 fwd, R=150 fwd: nothing yet one cycle after accept, driven after two.
    applyStimulus(2'b11, 1'b1, 2'b01, 1'b1);
    checkOutput("latency_first_cycle", dut_vec(), 8'b00_0000_10);
    idleCycles(1);
    checkOutput("forward_drive", dut_vec(), 8'b00_1010_10);

    // Left reverses to 220: four coast cycles, ready low, then in2 driven.
    applyStimulus(2'b10, 1'b0, 2'b01, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) idleCycles(1);
      checkOutput($sformatf("reversal_step%0d", i), dut_vec(), rev_exp[i]);
    end

    // Silence: expiry on the 20th edge after the reversal accept.
    idleCycles(14);
    checkOutput("wdog_not_yet", dut_vec(), 8'b00_0110_10);
    idleCycles(1);
    checkOutput("wdog_expire_edge", dut_vec(), 8'b00_0110_11);
    idleCycles(1);
    checkOutput("wdog_coast", dut_vec(), 8'b00_0000_11);

    // Next accept clears the flag; right reverse from IDLE needs no dead time.
    applyStimulus(2'b00, 1'b1, 2'b11, 1'b0);
    checkOutput("wdog_clear", dut_vec(), 8'b00_0000_10);
    idleCycles(1);
    checkOutput("reverse_from_idle", dut_vec(), 8'b00_0001_10);

    // Accept lands exactly on the would-be expiry edge.
    idleCycles(17);
    applyStimulus(2'b01, 1'b1, 2'b11, 1'b0);
    checkOutput("accept_on_expiry", dut_vec(), 8'b00_0001_10);
    idleCycles(1);
    checkOutput("accept_on_expiry_drive", dut_vec(), 8'b00_1001_10);

    // Reset in the middle of a left reversal discards the pending command.
    applyStimulus(2'b01, 1'b0, 2'b11, 1'b0);
    checkOutput("dead_entry", dut_vec(), 8'b00_1001_00);
    idleCycles(1);
    rst_n = 1'b0;
    idleCycles(1);
    rst_n = 1'b1;
    checkOutput("reset_in_dead", dut_vec(), 8'b00_0000_10);
    for (int i = 0; i < 6; i++) begin
      idleCycles(1);
      checkOutput("after_reset_idle", dut_vec(), 8'b00_0000_10);
    end

    // Random commands and PWM activity.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      {pwm_250, pwm_220, pwm_150} = 3'($urandom);
      pwm_0           = 1'b0;
      cmd_valid       = ($urandom_range(0, 5) == 0);
      cmd_left_speed  = 2'($urandom);
      cmd_left_dir    = 1'($urandom);
      cmd_right_speed = 2'($urandom);
      cmd_right_dir   = 1'($urandom);
      rst_n           = ($urandom_range(0, 2999) != 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    idleCycles(2);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
